inst_src_arb: RTL and testbench
===============================

# inst_src_arb

Arbiter and sequencer for the 32-bit, 8-input instruction-source mux in the signal unit. It shares the mux among eight requesters, such as the IMEM fetch, DMA, debug and host-inject paths. It drives the mux select lines `s2..s0` from a registered grant and holds the grant for a multi-word burst. It presents a single valid/ready stream to the downstream instruction buffer.

## Interface
Parameters:
- `MAX_BEATS`, default 16: maximum transfers per grant before a forced release. Legal range is 2..31.

Ports:
- `clk`, input, 1: the single clock for the block.
- `reset_l`, input, 1: reset, synchronous and active-low.
- `req`, input, 8: per-source request. Source i's data is valid on mux input i while `req[i]` is high.
- `last`, input, 8: per-source end-of-burst flag. It is qualified by the transfer of that source.
- `rdy`, input, 1: downstream instruction buffer accepts the mux output this cycle.
- `gnt`, output, 8: one-hot (or zero) registered grant.
- `s0`, `s1`, `s2`, output, 1 each: mux select, the binary encode of `gnt` (`s0` is the LSB). They are 0 when no grant is held.
- `vld`, output, 1: mux output valid, equal to `|(gnt & req)`.
- `xfer`, output, 1: transfer strobe, equal to `vld & rdy`.

## Operation
State machine:
- **IDLE**: `gnt` is 0.
  - If `|req` is set, pick a winner by round-robin, starting at `ptr+1` mod 8.
  - Register `gnt` and the select lines, and go to OWN.
- **OWN**: the grant is held.
  - The beat counter increments on each `xfer`.
  - Release happens on any of these conditions:
    - `xfer & last[sel]`;
    - an `xfer` that makes the count equal `MAX_BEATS` (forced release);
    - `req[sel]` is low while not transferring (abandon).
- **On release**:
  - `ptr` is set to `sel`.
  - In the same cycle, pick the next winner from the current `req`, excluding the releasing source unless it is the only requester.
  - If a winner exists, load its grant and stay in OWN; otherwise go to IDLE.
  - The beat counter is cleared.
- Grants are never preempted mid-burst.
- Requester rule: hold `req` high until its `last` transfer. A source that is force-released keeps `req` high and re-arbitrates normally.

## Timing
- Reset values: `gnt`=0, `s2..s0`=0, `vld`=0, `xfer`=0, `ptr`=7 (so source 0 wins first), beat counter=0, state IDLE. Reset asserted mid-burst aborts the burst in the next cycle; no transfer is reported after that edge.
- Request to grant is 1 cycle: `req` is sampled at edge N, and `gnt` and the select lines are valid after edge N+1.
- Back-to-back bursts have zero bubble: the new grant is active in the cycle after the releasing transfer.
- Select lines change only at clock edges. They are always consistent with `gnt` in the same cycle.
- Simultaneous `last` and count reaching `MAX_BEATS` produce a single release; the events are not counted twice.
- `rdy` low stalls the burst: the counter and grant hold.

## Configuration
- **`INST_ARB_PRIO0_EN` defined**: source 0 has strict priority at every arbitration point (IDLE pick and release pick), while it is not the releasing source. Round-robin among sources 1..7 otherwise. Source 0 still cannot preempt a burst in progress.
- **Undefined**: pure round-robin across all 8 sources.

## Structure
- Package `inst_arb_pkg` contains:
  - `NUM_SRC`=8 and `SEL_W`=3;
  - a state enum {IDLE, OWN};
  - a `onehot_to_sel` function.
- Sub-module `rr_pick8`: combinational rotating-priority encoder. Its inputs are `req[7:0]`, `ptr[2:0]` and an exclude mask; its outputs are a one-hot winner and `any`.
- The top level holds the FSM, `ptr`, the beat counter and the output registers.

## Test plan
- **Reset, then first grant**: reset low for 2 cycles, then `req`=8'h81 → cycle+1 `gnt`=8'h01, select=0. After `last[0]`, `gnt`=8'h80, select=7.
- **Round-robin fairness**: all `req`=8'hFF, every transfer carries `last`, `rdy`=1 → grant order 0,1,2,...,7,0; `xfer` high every cycle with no bubble.
- **Forced release**: `MAX_BEATS`=4, source 3 requests with `last` never set → after 4 `xfer`s, grant moves to another requester (or back to 3 if it is the only requester), and the count restarts.
- **Stall**: `rdy` low for 5 cycles mid-burst → `gnt` and select unchanged, counter unchanged, `xfer`=0 throughout.
- **Abandon and reset mid-burst**:
  - Source 5 drops `req` without `last` → grant released next cycle.
  - Reset asserted mid-burst → `gnt`=0 and `vld`=0 after the edge.
- **Priority (with `INST_ARB_PRIO0_EN`)**: source 2 bursting while source 0 requests → source 0 is granted at source 2's release, ahead of pending source 3. Without the macro, source 3 wins.

Source files
------------

// File: rtl/inst_src_arb_pkg.sv
// inst_arb_pkg: shared sizes, FSM state type and grant-to-select encode for inst_src_arb
package inst_arb_pkg;
  localparam int NUM_SRC = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, OWN} state_t;
  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [NUM_SRC-1:0] oh);
    logic [SEL_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_SRC; i++) if (oh[i]) s |= SEL_W'(i);
    return s;
  endfunction
endpackage

// File: rtl/inst_src_arb_if.sv
// inst_src_arb_if: requester/downstream stream bundle between the sources and the arbiter
interface inst_src_arb_if;
  import inst_arb_pkg::*;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] last;
  logic rdy;
  logic [NUM_SRC-1:0] gnt;
  logic s0;
  logic s1;
  logic s2;
  logic vld;
  logic xfer;
  modport master (output req, last, rdy, input gnt, s0, s1, s2, vld, xfer);
  modport slave (input req, last, rdy, output gnt, s0, s1, s2, vld, xfer);
endinterface

// File: rtl/inst_src_arb_rr_pick8.sv
// rr_pick8: rotating-priority encoder, first unmasked requester after ptr wins
module rr_pick8
  import inst_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_SRC-1:0] excl,
  output logic [NUM_SRC-1:0] win,
  output logic               any
);
  logic [NUM_SRC-1:0] r;
  assign r = req & ~excl;
  assign any = |r;
  always_comb begin
    win = '0;
    for (int k = NUM_SRC; k >= 1; k--) if (r[ptr + SEL_W'(k)]) win = NUM_SRC'(1) << (ptr + SEL_W'(k));
  end
endmodule

// File: rtl/inst_src_arb.sv
// inst_src_arb: burst-holding round-robin arbiter for the 8-input instruction-source mux
// INST_ARB_PRIO0_EN gives source 0 strict priority at every arbitration point
module inst_src_arb
  import inst_arb_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input logic clk,
  input logic reset_l,
  inst_src_arb_if.slave bus
);
  localparam logic [4:0] MAXB = 5'(MAX_BEATS);
  state_t st, st_n;
  logic [NUM_SRC-1:0] gnt, gnt_n, excl, rr_win, win;
  logic [SEL_W-1:0] sel, sel_n, ptr, ptr_n, pp;
  logic [4:0] cnt, cnt_n;
  logic vld, xfer, rel, any;
  assign vld = |(gnt & bus.req);
  assign xfer = vld & bus.rdy;
  assign bus.gnt = gnt;
  assign {bus.s2, bus.s1, bus.s0} = sel;
  assign bus.vld = vld;
  assign bus.xfer = xfer;
  assign rel = (st == OWN) && ((xfer && (bus.last[sel] || cnt + 5'd1 == MAXB)) || !bus.req[sel]);
  // the releasing source may only re-win when nobody else is asking
  assign excl = (st == OWN && bus.req != gnt) ? gnt : '0;
  assign pp = (st == OWN) ? sel : ptr;
  rr_pick8 u_pick (.req(bus.req), .ptr(pp), .excl(excl), .win(rr_win), .any(any));
`ifdef INST_ARB_PRIO0_EN
  assign win = (bus.req[0] && !excl[0]) ? NUM_SRC'(1) : rr_win;
`else
  assign win = rr_win;
`endif
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      st <= IDLE;
      gnt <= '0;
      sel <= '0;
      ptr <= 3'd7;
      cnt <= '0;
    end else begin
      st <= st_n;
      gnt <= gnt_n;
      sel <= sel_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    st_n = st;
    gnt_n = gnt;
    sel_n = sel;
    ptr_n = ptr;
    cnt_n = cnt;
    if (st == IDLE || rel) begin
      st_n = any ? OWN : IDLE;
      gnt_n = win;
      sel_n = onehot_to_sel(win);
      ptr_n = pp;
      cnt_n = '0;
    end else if (xfer) begin
      cnt_n = cnt + 5'd1;
    end
  end
endmodule

// File: tb/tb_inst_src_arb.sv
// tb_inst_src_arb: table-driven cycle vectors plus reset-mid-burst sequence, MAX_BEATS=4
module tb_inst_src_arb;
  typedef struct {
    logic [7:0] req;
    logic [7:0] last;
    logic rdy;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic vld;
    logic xfer;
  } vec_t;
`ifdef INST_ARB_PRIO0_EN
  localparam logic [7:0] PG = 8'h01, QG = 8'h08;
  localparam logic [2:0] PS = 3'd0, QS = 3'd3;
`else
  localparam logic [7:0] PG = 8'h08, QG = 8'h01;
  localparam logic [2:0] PS = 3'd3, QS = 3'd0;
`endif
  logic clk = 1'b0;
  logic reset_l;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tv[$];
  inst_src_arb_if bus();
  inst_src_arb #(.MAX_BEATS(4)) dut (.clk(clk), .reset_l(reset_l), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, i, act, exp);
    end
  endtask
  task automatic add(input logic [7:0] rq, input logic [7:0] ls, input logic rd, input logic [7:0] g, input logic [2:0] s, input logic v, input logic x);
    tv.push_back('{rq, ls, rd, g, s, v, x});
  endtask
  task automatic chk_all(input int i, input logic [7:0] g, input logic [2:0] s, input logic v, input logic x);
    chk("gnt", i, bus.gnt, g);
    chk("sel", i, {5'd0, bus.s2, bus.s1, bus.s0}, {5'd0, s});
    chk("vld", i, {7'd0, bus.vld}, {7'd0, v});
    chk("xfer", i, {7'd0, bus.xfer}, {7'd0, x});
  endtask
  initial begin
    add(8'h81, 8'h00, 1, 8'h00, 0, 0, 0);
    add(8'h81, 8'h01, 1, 8'h01, 0, 1, 1);
    add(8'h80, 8'h00, 1, 8'h80, 7, 1, 1);
    add(8'h80, 8'h80, 1, 8'h80, 7, 1, 1);
    add(8'h00, 8'h00, 1, 8'h80, 7, 0, 0);
    add(8'hFF, 8'hFF, 1, 8'h00, 0, 0, 0);
    for (int k = 0; k < 9; k++) add(8'hFF, 8'hFF, 1, 8'h01 << (k % 8), 3'(k % 8), 1, 1);
    add(8'h08, 8'h00, 1, 8'h02, 1, 0, 0);
    add(8'h08, 8'h00, 1, 8'h08, 3, 1, 1);
    add(8'h08, 8'h00, 1, 8'h08, 3, 1, 1);
    for (int k = 0; k < 5; k++) add(8'h08, 8'h00, 0, 8'h08, 3, 1, 0);
    add(8'h08, 8'h00, 1, 8'h08, 3, 1, 1);
    add(8'h08, 8'h00, 1, 8'h08, 3, 1, 1);
    for (int k = 0; k < 3; k++) add(8'h18, 8'h00, 1, 8'h08, 3, 1, 1);
    add(8'h18, 8'h08, 1, 8'h08, 3, 1, 1);
    add(8'h18, 8'h10, 1, 8'h10, 4, 1, 1);
    add(8'h08, 8'h08, 1, 8'h08, 3, 1, 1);
    add(8'h00, 8'h00, 1, 8'h08, 3, 0, 0);
    add(8'h00, 8'h00, 1, 8'h00, 0, 0, 0);
    add(8'h20, 8'h00, 1, 8'h00, 0, 0, 0);
    add(8'h20, 8'h00, 1, 8'h20, 5, 1, 1);
    add(8'h00, 8'h00, 1, 8'h20, 5, 0, 0);
    add(8'h00, 8'h00, 1, 8'h00, 0, 0, 0);
    add(8'h04, 8'h00, 1, 8'h00, 0, 0, 0);
    add(8'h0D, 8'h00, 1, 8'h04, 2, 1, 1);
    add(8'h0D, 8'h04, 1, 8'h04, 2, 1, 1);
    add(8'h09, 8'h09, 1, PG, PS, 1, 1);
    add(8'h00, 8'h00, 1, QG, QS, 0, 0);
    add(8'h00, 8'h00, 1, 8'h00, 0, 0, 0);
    reset_l = 1'b0;
    bus.req = '0;
    bus.last = '0;
    bus.rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_all(-1, 8'h00, 0, 0, 0);
    reset_l = 1'b1;
    foreach (tv[i]) begin
      bus.req = tv[i].req;
      bus.last = tv[i].last;
      bus.rdy = tv[i].rdy;
      #1;
      chk_all(i, tv[i].gnt, tv[i].sel, tv[i].vld, tv[i].xfer);
      @(negedge clk);
    end
    bus.req = 8'h02;
    bus.last = 8'h00;
    bus.rdy = 1'b1;
    @(negedge clk);
    #1;
    chk_all(100, 8'h02, 1, 1, 1);
    reset_l = 1'b0;
    @(negedge clk);
    #1;
    chk_all(101, 8'h00, 0, 0, 0);
    reset_l = 1'b1;
    bus.req = 8'h03;
    @(negedge clk);
    #1;
    chk_all(102, 8'h01, 0, 1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
